// File: rtl/mem_pkg.sv
// mem_pkg
// Shared constants for the data memory and the pipeline decoder.
// MemOp values are the RISC-V load/store funct3 encodings.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/load_extend.sv
// load_extend
// Picks the byte, halfword or word addressed by a load out of a 32-bit
// memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   word_i    32-bit word read from storage
//   offset_i  byte offset within the word (addr[1:0])
//   MemOp_i   load type (funct3)
//   ext_o     extended load result; 0 for unsupported encodings
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  MemOp_i,
  output logic [31:0] ext_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane selection: byte by the full offset, halfword by offset[1] only
  // (offset[0] is ignored for halfwords, which forces alignment).
  always_comb begin
    byteSel = word_i[7:0];
    case (offset_i)
      2'd0:    byteSel = word_i[7:0];
      2'd1:    byteSel = word_i[15:8];
      2'd2:    byteSel = word_i[23:16];
      default: byteSel = word_i[31:24];
    endcase
    halfSel = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extension according to load type; 011/110/111 return zero.
  always_comb begin
    ext_o = '0;
    case (MemOp_i)
      MEM_B:   ext_o = {{24{byteSel[7]}}, byteSel};
      MEM_BU:  ext_o = {24'h0, byteSel};
      MEM_H:   ext_o = {{16{halfSel[15]}}, halfSel};
      MEM_HU:  ext_o = {16'h0, halfSel};
      MEM_W:   ext_o = word_i;
      default: ext_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// data_memory
// Byte-addressable little-endian data memory for the MEM stage.
// Stores (SB/SH/SW) commit on the rising clock edge; loads are
// combinational. Upper address bits are ignored, so addresses wrap.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset, clears all words
//   MemOp      access type (funct3)
//   addr       byte address
//   WriteData  right-aligned store data
//   MemRead    load enable (ReadData is 0 when low)
//   MemWrite   store enable
//   ReadData   extended load result
module data_memory
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS   = 1024,
  parameter int ADDR_LSB_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  MemOp,
  input  logic [31:0] addr,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData
);

  localparam int IDX_BITS = $clog2(DEPTH_WORDS);
  localparam int IDX_TOP  = IDX_BITS + ADDR_LSB_BITS - 1;

  logic [31:0]         mem_q [DEPTH_WORDS];
  logic [IDX_BITS-1:0] wordIdx;
  logic [1:0]          byteOff;
  logic [31:0]         rdWord;
  logic [3:0]          byteEn;
  logic [31:0]         wrLanes;
  logic [31:0]         word_d;
  logic [31:0]         extWord;
  logic                unusedAddrBits;

  assign wordIdx = addr[IDX_TOP:ADDR_LSB_BITS];
  assign byteOff = addr[1:0];
  assign rdWord  = mem_q[wordIdx];

  // Address bits above the array are deliberately ignored (wrap-around).
  assign unusedAddrBits = ^addr[31:IDX_TOP+1];

  // Store byte enables, with the store data replicated across lanes so each
  // enabled lane simply takes its own slice of wrLanes.
  always_comb begin
    byteEn  = 4'b0000;
    wrLanes = WriteData;
    case (MemOp)
      MEM_B: begin
        byteEn  = 4'b0001 << byteOff;
        wrLanes = {4{WriteData[7:0]}};
      end
      MEM_H: begin
        byteEn  = byteOff[1] ? 4'b1100 : 4'b0011;
        wrLanes = {2{WriteData[15:0]}};
      end
      MEM_W: begin
        byteEn  = 4'b1111;
        wrLanes = WriteData;
      end
      default: begin
        byteEn  = 4'b0000;
        wrLanes = WriteData;
      end
    endcase
  end

  // Merge enabled lanes into the current word; disabled lanes keep contents.
  always_comb begin
    word_d = rdWord;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (byteEn[b]) begin
        word_d[8*b +: 8] = wrLanes[8*b +: 8];
      end
    end
  end

  // Storage: reset clears everything asynchronously, and a low rst_n at an
  // edge therefore also drops any pending store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (MemWrite && (byteEn != 4'b0000)) begin
      mem_q[wordIdx] <= word_d;
    end
  end

  load_extend uLoadExtend (
    .word_i   (rdWord),
    .offset_i (byteOff),
    .MemOp_i  (MemOp),
    .ext_o    (extWord)
  );

  // Reads see pre-write contents in a read+write cycle since mem_q only
  // changes at the edge.
  assign ReadData = MemRead ? extWord : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory
// Directed bench for data_memory. Stimulus pushes the expected ReadData
// into a scoreboard queue and fires a sample event; a separate monitor
// pops and compares one time step later.
module tb_data_memory;
  import mem_pkg::*;

  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] expVal;
    string       name;
  } sbEntry_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  MemOp;
  logic [31:0] addr;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;

  sbEntry_t scoreboard[$];
  event     sampleEv;
  int       testsRun    = 0;
  int       testsFailed = 0;

  data_memory #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemOp     (MemOp),
    .addr      (addr),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: each sample request compares ReadData with the oldest entry.
  initial begin
    sbEntry_t e;
    forever begin
      @(sampleEv);
      #1;
      testsRun++;
      if (scoreboard.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL scoreboard_empty: got %h with no expected value", ReadData);
      end else begin
        e = scoreboard.pop_front();
        if (ReadData !== e.expVal) begin
          testsFailed++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, ReadData, e.expVal);
        end
      end
    end
  end

  // One store, driven at the falling edge and committed at the next rising edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] d);
    @(negedge clk);
    MemOp     = op;
    addr      = a;
    WriteData = d;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    @(negedge clk);
    MemWrite  = 1'b0;
  endtask

  // Set up a read and queue its expected value; no clock edge is consumed.
  task automatic checkOutput(input logic [2:0] op, input logic [31:0] a,
                             input logic rd, input logic [31:0] expVal,
                             input string name);
    sbEntry_t e;
    MemOp   = op;
    addr    = a;
    MemRead = rd;
    e.expVal = expVal;
    e.name   = name;
    scoreboard.push_back(e);
    ->sampleEv;
    #2;
  endtask

  initial begin
    MemOp     = MEM_W;
    addr      = '0;
    WriteData = '0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    checkOutput(MEM_B, 32'h4, 1'b1, 32'h0, "reset_lb_during");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput(MEM_B, 32'h4, 1'b1, 32'h0, "reset_lb_after");

    // Byte then halfword store into word 0.
    applyStimulus(MEM_B, 32'h0, 32'h000000FF);
    applyStimulus(MEM_H, 32'h2, 32'h0000EEEE);
    checkOutput(MEM_W,  32'h0, 1'b1, 32'hEEEE00FF, "lw_0");
    checkOutput(MEM_B,  32'h0, 1'b1, 32'hFFFFFFFF, "lb_0");
    checkOutput(MEM_BU, 32'h0, 1'b1, 32'h000000FF, "lbu_0");
    checkOutput(MEM_H,  32'h2, 1'b1, 32'hFFFFEEEE, "lh_2");
    checkOutput(MEM_HU, 32'h2, 1'b1, 32'h0000EEEE, "lhu_2");
    checkOutput(MEM_B,  32'h1, 1'b1, 32'h00000000, "lb_1");
    checkOutput(MEM_H,  32'h3, 1'b1, 32'hFFFFEEEE, "lh_3_aligned");
    checkOutput(3'b011, 32'h0, 1'b1, 32'h00000000, "op011_zero");
    checkOutput(MEM_B,  32'h3, 1'b1, 32'hFFFFFFEE, "lb_3");

    // Word store then byte override of the top lane.
    applyStimulus(MEM_W, 32'h8, 32'h12345678);
    applyStimulus(MEM_B, 32'hB, 32'h000000AB);
    checkOutput(MEM_W, 32'h8, 1'b1, 32'hAB345678, "lw_8");
    checkOutput(MEM_W, 32'h8, 1'b0, 32'h00000000, "memread_low");
    checkOutput(MEM_HU, 32'hA, 1'b1, 32'h0000AB34, "lhu_a");

    // Odd-address halfword store lands on the aligned lane pair.
    applyStimulus(MEM_H, 32'h11, 32'h0000BEEF);
    checkOutput(MEM_W, 32'h10, 1'b1, 32'h0000BEEF, "sh_odd_addr");

    // Same-cycle read and write.
    applyStimulus(MEM_W, 32'hC, 32'h11111111);
    @(negedge clk);
    MemOp     = MEM_W;
    addr      = 32'hC;
    WriteData = 32'h22222222;
    MemWrite  = 1'b1;
    checkOutput(MEM_W, 32'hC, 1'b1, 32'h11111111, "rw_before_edge");
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    checkOutput(MEM_W, 32'hC, 1'b1, 32'h22222222, "rw_after_edge");

    // Address wrap, then mid-cycle reset.
    applyStimulus(MEM_W, 32'h4 * DEPTH, 32'hCAFEF00D);
    checkOutput(MEM_W, 32'h0, 1'b1, 32'hCAFEF00D, "wrap_lw_0");
    #1 rst_n = 1'b0;
    checkOutput(MEM_W, 32'h0, 1'b1, 32'h00000000, "async_reset_clear");

    // A store held across an edge while in reset is dropped.
    MemOp     = MEM_W;
    addr      = 32'h14;
    WriteData = 32'h5A5A5A5A;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    rst_n    = 1'b1;
    checkOutput(MEM_W, 32'h14, 1'b1, 32'h00000000, "store_dropped_in_reset");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && scoreboard.size() != 0; i++) @(negedge clk);
    if (scoreboard.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", scoreboard.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
